// File: rtl/snake_pkg.sv
// Shared direction codes, game FSM encoding and helpers for the snake move scheduler.
package snake_pkg;

  localparam int unsigned DIR_W   = 2;
  localparam int unsigned NUM_BTN = 4;

  localparam logic [DIR_W-1:0] DIR_UP    = 2'b00;
  localparam logic [DIR_W-1:0] DIR_LEFT  = 2'b01;
  localparam logic [DIR_W-1:0] DIR_RIGHT = 2'b10;
  localparam logic [DIR_W-1:0] DIR_DOWN  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10
  } state_t;

  // Direction codes are chosen so that the reverse of a heading is its bitwise complement.
  function automatic logic [DIR_W-1:0] opposite(input logic [DIR_W-1:0] d);
    return ~d;
  endfunction

endpackage

// File: rtl/btn_edge_sync.sv
// Synchronises the four active-low buttons and flags each 1->0 transition for one cycle.
module btn_edge_sync
  import snake_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_BTN-1:0] btn_n,
  output logic [NUM_BTN-1:0] fall_c
);

  logic [NUM_BTN-1:0] sync_q [SYNC_STAGES];
  logic [NUM_BTN-1:0] prev_q;

  // Released buttons read high, so all flops reset to 1 to avoid a false press after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '1;
      end
      prev_q <= '1;
    end else begin
      sync_q[0] <= btn_n;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign fall_c = prev_q & ~sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/snake_move_scheduler.sv
// Game FSM, move-tick generator and validated turn queue for the snake head.
// Define TURN_QUEUE_EN for a DEPTH-entry turn FIFO; otherwise a single overwriting pending turn is kept.
module snake_move_scheduler
  import snake_pkg::*;
#(
  parameter int unsigned TICK_BASE   = 25_000_000,
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_BTN-1:0]           btn_n,
  input  logic                         start,
  input  logic                         pause,
  input  logic                         game_over,
  input  logic [1:0]                   speed_sel,
  output logic [DIR_W-1:0]             direction,
  output logic                         move_tick,
  output logic                         running,
  output logic [$clog2(DEPTH+1)-1:0]   q_count,
  output logic                         drop_pulse
);

  localparam int unsigned CNT_W  = $clog2(DEPTH + 1);
  localparam int unsigned TICK_W = $clog2(TICK_BASE + 1);

  state_t             state_q;
  state_t             state_d;
  logic               enter_run_c;
  logic               clear_c;
  logic [NUM_BTN-1:0] fall_c;
  logic [TICK_W-1:0]  cnt_q;
  logic [31:0]        period_c;
  logic               tick_hit_c;
  logic               tick_go_c;
  logic               evt_valid_c;
  logic [DIR_W-1:0]   evt_dir_c;
  logic               take_c;
  logic               reject_c;
  logic               push_c;
  logic               pop_c;
  logic [DIR_W-1:0]   head_c;

  btn_edge_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_btn_edge_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .btn_n  (btn_n),
    .fall_c (fall_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // game_over outranks pause, pause outranks start.
  always_comb begin
    state_d     = state_q;
    enter_run_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start && !pause && !game_over) begin
          state_d     = ST_RUN;
          enter_run_c = 1'b1;
        end
      end
      ST_RUN: begin
        if (game_over) begin
          state_d = ST_IDLE;
        end else if (pause) begin
          state_d = ST_PAUSE;
        end
      end
      ST_PAUSE: begin
        if (game_over) begin
          state_d = ST_IDLE;
        end else if (pause) begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign clear_c = enter_run_c || (game_over && (state_q != ST_IDLE));

  // Move period with a floor of 2; >= lets a shorter period take effect on the spot.
  always_comb begin
    period_c = TICK_BASE >> speed_sel;
    if (period_c < 32'd2) begin
      period_c = 32'd2;
    end
  end

  assign tick_hit_c = (state_q == ST_RUN) && (32'(cnt_q) >= (period_c - 32'd1));
  assign tick_go_c  = tick_hit_c && !game_over;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if ((state_q == ST_RUN) && !game_over && !tick_hit_c) begin
      cnt_q <= cnt_q + TICK_W'(1);
    end else if (state_q != ST_PAUSE) begin
      cnt_q <= '0;
    end
  end

  // Bit index equals direction code, so priority up>left>right>down is lowest-bit-first.
  always_comb begin
    evt_valid_c = |fall_c;
    evt_dir_c   = DIR_UP;
    if (fall_c[0]) begin
      evt_dir_c = DIR_UP;
    end else if (fall_c[1]) begin
      evt_dir_c = DIR_LEFT;
    end else if (fall_c[2]) begin
      evt_dir_c = DIR_RIGHT;
    end else if (fall_c[3]) begin
      evt_dir_c = DIR_DOWN;
    end
  end

  assign take_c = evt_valid_c && (state_q == ST_RUN) && !game_over;
  assign pop_c  = tick_go_c && (q_count != '0);
  assign push_c = take_c && !reject_c;

`ifdef TURN_QUEUE_EN
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DIR_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [DIR_W-1:0] ref_c;
  logic             full_c;

  // Turns are checked against the newest queued turn so a chain of turns stays legal.
  always_comb begin
    ref_c    = (q_count != '0) ? mem_q[wr_ptr_q - PTR_W'(1)] : direction;
    full_c   = (q_count == CNT_W'(DEPTH));
    reject_c = take_c && ((evt_dir_c == ref_c) || (evt_dir_c == opposite(ref_c)) || full_c);
    head_c   = mem_q[rd_ptr_q];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= DIR_UP;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      q_count  <= '0;
    end else if (clear_c) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      q_count  <= '0;
    end else begin
      if (push_c) begin
        mem_q[wr_ptr_q] <= evt_dir_c;
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (pop_c) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      if (push_c && !pop_c) begin
        q_count <= q_count + CNT_W'(1);
      end else if (pop_c && !push_c) begin
        q_count <= q_count - CNT_W'(1);
      end
    end
  end
`else
  logic [DIR_W-1:0] pend_q;

  // A newer legal press simply replaces the pending one; only the current heading matters.
  always_comb begin
    reject_c = take_c && ((evt_dir_c == direction) || (evt_dir_c == opposite(direction)));
    head_c   = pend_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q  <= DIR_UP;
      q_count <= '0;
    end else if (clear_c) begin
      q_count <= '0;
    end else if (push_c) begin
      pend_q  <= evt_dir_c;
      q_count <= CNT_W'(1);
    end else if (pop_c) begin
      q_count <= '0;
    end
  end
`endif

  // Direction updates on the same edge that raises move_tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      direction  <= DIR_DOWN;
      move_tick  <= 1'b0;
      running    <= 1'b0;
      drop_pulse <= 1'b0;
    end else begin
      move_tick  <= tick_go_c;
      running    <= (state_d == ST_RUN);
      drop_pulse <= reject_c;
      if (enter_run_c) begin
        direction <= DIR_DOWN;
      end else if (pop_c) begin
        direction <= head_c;
      end
    end
  end

endmodule

// File: tb/tb_snake_move_scheduler.sv
// Scoreboard bench for snake_move_scheduler (TICK_BASE=8, DEPTH=4); expectations follow TURN_QUEUE_EN.
module tb_snake_move_scheduler;

  localparam int unsigned TICK_BASE   = 8;
  localparam int unsigned DEPTH       = 4;
  localparam int unsigned SYNC_STAGES = 2;
  localparam int unsigned CNT_W       = $clog2(DEPTH + 1);

  localparam int S_DIR  = 0;
  localparam int S_MT   = 1;
  localparam int S_RUN  = 2;
  localparam int S_Q    = 3;
  localparam int S_DROP = 4;

  localparam logic [3:0] B_UP    = 4'b0001;
  localparam logic [3:0] B_LEFT  = 4'b0010;
  localparam logic [3:0] B_RIGHT = 4'b0100;
  localparam logic [3:0] B_DOWN  = 4'b1000;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [3:0]       btn_n;
  logic             start;
  logic             pause;
  logic             game_over;
  logic [1:0]       speed_sel;
  logic [1:0]       direction;
  logic             move_tick;
  logic             running;
  logic [CNT_W-1:0] q_count;
  logic             drop_pulse;

  snake_move_scheduler #(
    .TICK_BASE  (TICK_BASE),
    .DEPTH      (DEPTH),
    .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn_n     (btn_n),
    .start     (start),
    .pause     (pause),
    .game_over (game_over),
    .speed_sel (speed_sel),
    .direction (direction),
    .move_tick (move_tick),
    .running   (running),
    .q_count   (q_count),
    .drop_pulse(drop_pulse)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int cyc; int dir; } tick_e_t;
  typedef struct { int sel; int exp; int tag; } chk_t;

  tick_e_t tick_q[$];
  int      drop_q[$];
  chk_t    chk_q[$];
  int      n_vec = 0;
  int      n_mis = 0;

  function automatic string sig_name(input int sel);
    case (sel)
      S_DIR:   return "direction";
      S_MT:    return "move_tick";
      S_RUN:   return "running";
      S_Q:     return "q_count";
      default: return "drop_pulse";
    endcase
  endfunction

  function automatic int sig_val(input int sel);
    case (sel)
      S_DIR:   return int'(direction);
      S_MT:    return int'(move_tick);
      S_RUN:   return int'(running);
      S_Q:     return int'(q_count);
      default: return int'(drop_pulse);
    endcase
  endfunction

  // Monitor: consumes expected ticks/drops/state checks whenever the DUT shows them.
  always begin
    tick_e_t te;
    chk_t    c;
    int      dc;
    @(negedge clk or negedge rst_n);
    #1;
    while (tick_q.size() > 0 && tick_q[0].cyc < cyc) begin
      te = tick_q.pop_front();
      n_vec++; n_mis++;
      $display("FAIL tick_missing: move_tick expected at cycle %0d dir %0d did not occur", te.cyc, te.dir);
    end
    if (move_tick === 1'b1) begin
      n_vec++;
      if (tick_q.size() > 0 && tick_q[0].cyc == cyc) begin
        te = tick_q.pop_front();
        if (int'(direction) != te.dir) begin
          n_mis++;
          $display("FAIL tick_dir: cycle %0d got direction %0d, required %0d", cyc, direction, te.dir);
        end
      end else begin
        n_mis++;
        $display("FAIL tick_unexpected: move_tick at cycle %0d, required 0", cyc);
      end
    end
    while (drop_q.size() > 0 && drop_q[0] < cyc) begin
      dc = drop_q.pop_front();
      n_vec++; n_mis++;
      $display("FAIL drop_missing: drop_pulse expected at cycle %0d did not occur", dc);
    end
    if (drop_pulse === 1'b1) begin
      n_vec++;
      if (drop_q.size() > 0 && drop_q[0] == cyc) begin
        dc = drop_q.pop_front();
      end else begin
        n_mis++;
        $display("FAIL drop_unexpected: drop_pulse at cycle %0d, required 0", cyc);
      end
    end
    while (chk_q.size() > 0) begin
      c = chk_q.pop_front();
      n_vec++;
      if (sig_val(c.sel) != c.exp) begin
        n_mis++;
        $display("FAIL chk%0d_%s: cycle %0d got %0d, required %0d",
                 c.tag, sig_name(c.sel), cyc, sig_val(c.sel), c.exp);
      end
    end
  end

  task automatic goto(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic exp_tick(input int c, input int d);
    tick_q.push_back('{c, d});
  endtask

  task automatic exp_drop(input int c);
    drop_q.push_back(c);
  endtask

  task automatic chk(input int sel, input int exp, input int tag);
    chk_q.push_back('{sel, exp, tag});
  endtask

  task automatic press(input int c, input logic [3:0] mask);
    goto(c);
    btn_n = ~mask;
    goto(c + 1);
    btn_n = 4'hF;
  endtask

  task automatic do_start(output int k);
    k = cyc + 1;
    goto(k);
    start = 1'b1;
    goto(k + 1);
    start = 1'b0;
  endtask

  task automatic pulse_go(input int c);
    goto(c);
    game_over = 1'b1;
    goto(c + 1);
    game_over = 1'b0;
  endtask

  task automatic pulse_pause(input int c);
    goto(c);
    pause = 1'b1;
    goto(c + 1);
    pause = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int qexp;
    rst_n     = 1'b0;
    btn_n     = 4'hF;
    start     = 1'b0;
    pause     = 1'b0;
    game_over = 1'b0;
    speed_sel = 2'd0;
    chk(S_DIR, 3, 0); chk(S_MT, 0, 0); chk(S_RUN, 0, 0); chk(S_Q, 0, 0); chk(S_DROP, 0, 0);
    goto(3);
    rst_n = 1'b1;

    // Free run: a tick every 8 cycles, heading stays down.
    do_start(k);
    exp_tick(k + 9, 3); exp_tick(k + 17, 3); exp_tick(k + 25, 3);
    goto(k + 2);
    chk(S_RUN, 1, 1); chk(S_Q, 0, 1); chk(S_DIR, 3, 1);
    pulse_go(k + 26);
    goto(cyc + 2);
    chk(S_RUN, 0, 1);

    // Right then up.
    do_start(k);
`ifdef TURN_QUEUE_EN
    exp_tick(k + 9, 2); exp_tick(k + 17, 0); exp_tick(k + 25, 0);
    qexp = 2;
`else
    exp_drop(k + 5);
    exp_tick(k + 9, 2); exp_tick(k + 17, 2); exp_tick(k + 25, 2);
    qexp = 1;
`endif
    press(k + 1, B_RIGHT);
    press(k + 2, B_UP);
    goto(k + 6);
    chk(S_Q, qexp, 2);
    pulse_go(k + 26);

    // Reversal then duplicate are both dropped.
    do_start(k);
    exp_drop(k + 4); exp_drop(k + 5); exp_tick(k + 9, 3);
    press(k + 1, B_UP);
    press(k + 2, B_DOWN);
    goto(k + 6);
    chk(S_Q, 0, 3); chk(S_DIR, 3, 3);
    pulse_go(k + 10);

    // Five legal-looking presses before the first tick: left, up, right, down, left.
    do_start(k);
`ifdef TURN_QUEUE_EN
    exp_drop(k + 8);
    exp_tick(k + 9, 1); exp_tick(k + 17, 0); exp_tick(k + 25, 2);
    exp_tick(k + 33, 3); exp_tick(k + 41, 3);
    qexp = 4;
`else
    exp_drop(k + 5); exp_drop(k + 7);
    exp_tick(k + 9, 1); exp_tick(k + 17, 1);
    qexp = 1;
`endif
    press(k + 1, B_LEFT);
    press(k + 2, B_UP);
    press(k + 3, B_RIGHT);
    press(k + 4, B_DOWN);
    press(k + 5, B_LEFT);
    goto(k + 8);
    chk(S_Q, qexp, 4);
`ifdef TURN_QUEUE_EN
    goto(k + 34);
    chk(S_Q, 0, 4);
    pulse_go(k + 42);
`else
    pulse_go(k + 18);
`endif

    // Pause at counter 5, press during pause, resume.
    do_start(k);
    exp_tick(k + 30, 3); exp_tick(k + 38, 3);
    pulse_pause(k + 6);
    goto(k + 8);
    chk(S_RUN, 0, 5);
    press(k + 10, B_LEFT);
    goto(k + 16);
    chk(S_Q, 0, 5); chk(S_DIR, 3, 5);
    pulse_pause(k + 27);
    goto(k + 29);
    chk(S_RUN, 1, 5);
    pulse_go(k + 39);

    // game_over on the tick cycle suppresses the tick and clears the queue.
    do_start(k);
    press(k + 1, B_RIGHT);
    goto(k + 6);
    chk(S_Q, 1, 6);
    pulse_go(k + 8);
    goto(k + 9);
    chk(S_RUN, 0, 6); chk(S_Q, 0, 6); chk(S_MT, 0, 6); chk(S_DIR, 3, 6);
    goto(k + 20);

    // Left and right together: left wins, right is discarded silently.
    do_start(k);
    exp_tick(k + 9, 1);
    press(k + 1, B_LEFT | B_RIGHT);
    goto(k + 5);
    chk(S_Q, 1, 7);
    pulse_go(k + 10);

    // Asynchronous reset while move_tick is high.
    do_start(k);
    exp_tick(k + 9, 2);
`ifdef TURN_QUEUE_EN
    qexp = 2;
`else
    exp_drop(k + 5);
    qexp = 1;
`endif
    press(k + 1, B_RIGHT);
    press(k + 2, B_UP);
    goto(k + 6);
    chk(S_Q, qexp, 8);
    goto(k + 9);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    chk(S_DIR, 3, 8); chk(S_MT, 0, 8); chk(S_RUN, 0, 8); chk(S_Q, 0, 8); chk(S_DROP, 0, 8);
    goto(k + 11);
    rst_n = 1'b1;
    goto(cyc + 4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
